// File: rtl/fp16_pkg.sv
// Shared constants and the stage-1 register payload for the float16 multiplier normalize/round stage.
package fp16_pkg;

  localparam int unsigned FRAC_W = 10;
  localparam int unsigned IEXP_W = 8;
  localparam int unsigned RES_W  = 16;

  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [RES_W-1:0] QNAN = 16'h7E00;

  // Normalized product held between the two pipeline stages
  typedef struct packed {
    logic              sign;
    logic [IEXP_W-1:0] exp;
    logic [FRAC_W-1:0] frac;
    logic              guard;
    logic              sticky;
    logic              zero;
    logic              inf;
    logic              nan;
  } s1_t;

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even of a 10-bit fraction with guard/sticky; carry flags fraction wrap to zero.
module fp16_round_rne
  import fp16_pkg::*;
(
  input  logic [FRAC_W-1:0] frac,
  input  logic              guard,
  input  logic              sticky,
  output logic [FRAC_W-1:0] frac_r,
  output logic              carry
);

  logic round_up;

  assign round_up        = guard & (sticky | frac[0]);
  assign {carry, frac_r} = {1'b0, frac} + (FRAC_W+1)'(round_up);

endmodule

// File: rtl/fp16_mult_normalize.sv
// Float16 multiplier back end: normalize, RNE round and pack, two-stage valid/ready pipeline.
// Optional gradual underflow: define FP16_MULT_SUBNORMAL_EN, otherwise tiny results flush to zero.
module fp16_mult_normalize
  import fp16_pkg::*;
#(
  parameter int unsigned EXP_W  = 7,
  parameter int unsigned MANT_W = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sign_in,
  input  logic [EXP_W-1:0]  exp_in,
  input  logic [MANT_W-1:0] mant_in,
  input  logic              nan_in,
  input  logic              inf_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  result,
  output logic              ovf,
  output logic              unf,
  output logic              inexact
);

  localparam logic signed [IEXP_W-1:0] EXP_MAX_S = IEXP_W'(EXP_MAX);

  s1_t s1_d, s1_q;
  logic v1;
  logic ready1, ready2;

  logic signed [IEXP_W-1:0] e_pre, e_rnd;
  logic [FRAC_W-1:0] n_frac;
  logic              n_carry;

  logic [RES_W-1:0] res_d;
  logic             ovf_d, unf_d, inx_d;

  assign ready2   = !out_valid || out_ready;
  assign ready1   = !v1 || ready2;
  assign in_ready = ready1;

  // Stage 1 datapath: pick the fraction window from the product's leading bit
  always_comb begin
    s1_d      = '0;
    s1_d.sign = sign_in;
    s1_d.nan  = nan_in;
    s1_d.inf  = inf_in;
    s1_d.zero = (mant_in == '0);
    if (mant_in[MANT_W-1]) begin
      s1_d.frac   = mant_in[MANT_W-2:MANT_W-11];
      s1_d.guard  = mant_in[MANT_W-12];
      s1_d.sticky = |mant_in[MANT_W-13:0];
      s1_d.exp    = IEXP_W'(signed'(exp_in)) + IEXP_W'(1);
    end else begin
      s1_d.frac   = mant_in[MANT_W-3:MANT_W-12];
      s1_d.guard  = mant_in[MANT_W-13];
      s1_d.sticky = |mant_in[MANT_W-14:0];
      s1_d.exp    = IEXP_W'(signed'(exp_in));
    end
  end

  // Stage 1 register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      s1_q <= '0;
    end else if (ready1) begin
      v1 <= in_valid;
      if (in_valid) s1_q <= s1_d;
    end
  end

  fp16_round_rne u_rne_norm (
    .frac   (s1_q.frac),
    .guard  (s1_q.guard),
    .sticky (s1_q.sticky),
    .frac_r (n_frac),
    .carry  (n_carry)
  );

  assign e_pre = s1_q.exp;
  assign e_rnd = e_pre + IEXP_W'(n_carry);

`ifdef FP16_MULT_SUBNORMAL_EN
  logic [IEXP_W-1:0] neg_exp;
  logic [3:0]        sh_m1;
  logic [22:0]       ext;
  logic [FRAC_W-1:0] sub_frac, s_frac;
  logic              sub_guard, sub_sticky, s_carry, sub_inx;

  // Denormalize: shift {1,frac,guard} right by 1-exp (max 12), collecting lost bits into sticky
  always_comb begin
    neg_exp    = IEXP_W'(0) - s1_q.exp;
    sh_m1      = (neg_exp > IEXP_W'(11)) ? 4'd11 : neg_exp[3:0];
    ext        = {1'b1, s1_q.frac, s1_q.guard, 11'h0} >> sh_m1;
    sub_frac   = ext[22:13];
    sub_guard  = ext[12];
    sub_sticky = s1_q.sticky | (|ext[11:0]);
    sub_inx    = sub_guard | sub_sticky;
  end

  fp16_round_rne u_rne_sub (
    .frac   (sub_frac),
    .guard  (sub_guard),
    .sticky (sub_sticky),
    .frac_r (s_frac),
    .carry  (s_carry)
  );
`endif

  // Stage 2 datapath: special-case priority, overflow and underflow handling, packing
  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = 1'b0;
    if (s1_q.nan) begin
      res_d = QNAN;
    end else if (s1_q.inf) begin
      res_d = {s1_q.sign, 5'h1F, 10'h0};
    end else if (s1_q.zero) begin
      res_d = {s1_q.sign, 15'h0};
    end else if (e_rnd >= EXP_MAX_S) begin
      res_d = {s1_q.sign, 5'h1F, 10'h0};
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (e_pre <= 0) begin
`ifdef FP16_MULT_SUBNORMAL_EN
      // A carry out of the fraction lands in the exponent LSB, giving the minimum normal
      res_d = {s1_q.sign, 4'h0, s_carry, s_frac};
      inx_d = sub_inx;
      unf_d = sub_inx | ({s_carry, s_frac} == '0);
`else
      res_d = {s1_q.sign, 15'h0};
      unf_d = 1'b1;
      inx_d = 1'b1;
`endif
    end else begin
      res_d = {s1_q.sign, e_rnd[4:0], n_frac};
      inx_d = s1_q.guard | s1_q.sticky;
    end
  end

  // Stage 2 register: result and flags advance together
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      inexact   <= 1'b0;
    end else if (ready2) begin
      out_valid <= v1;
      if (v1) begin
        result  <= res_d;
        ovf     <= ovf_d;
        unf     <= unf_d;
        inexact <= inx_d;
      end
    end
  end

endmodule

// File: tb/tb_fp16_mult_normalize.sv
// Directed self-checking bench for fp16_mult_normalize (follows FP16_MULT_SUBNORMAL_EN if defined).
module tb_fp16_mult_normalize;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign_in;
  logic [6:0]  exp_in;
  logic [21:0] mant_in;
  logic        nan_in;
  logic        inf_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        ovf;
  logic        unf;
  logic        inexact;

  int total = 0;
  int bad   = 0;

  fp16_mult_normalize dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign_in   (sign_in),
    .exp_in    (exp_in),
    .mant_in   (mant_in),
    .nan_in    (nan_in),
    .inf_in    (inf_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One isolated beat with out_ready high: checks acceptance, 2-cycle latency, result and flags
  task automatic beat(input string tag, input logic s, input logic [6:0] e, input logic [21:0] m,
                      input logic n, input logic i, input logic [15:0] r,
                      input logic o, input logic u, input logic x);
    int lat;
    @(posedge clk); #1;
    sign_in = s; exp_in = e; mant_in = m; nan_in = n; inf_in = i;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 8);
    chk({tag, ".latency"}, 32'(lat), 32'd2);
    chk({tag, ".result"}, 32'(result), 32'(r));
    chk({tag, ".ovf"}, 32'(ovf), 32'(o));
    chk({tag, ".unf"}, 32'(unf), 32'(u));
    chk({tag, ".inexact"}, 32'(inexact), 32'(x));
  endtask

  logic [6:0]  bp_e [4] = '{7'd15, 7'd15, 7'd16, 7'd14};
  logic [21:0] bp_m [4] = '{22'h100000, 22'h240000, 22'h100000, 22'h100000};
  logic [15:0] bp_r [4] = '{16'h3C00, 16'h4080, 16'h4000, 16'h3800};

  initial begin
    logic [15:0] got [$];
    logic [15:0] held;
    logic        stall_prev;
    logic        saw_low;
    int          idx;
    int          emitted;

    rst_n = 1'b0; in_valid = 1'b0; sign_in = 1'b0; exp_in = '0; mant_in = '0;
    nan_in = 1'b0; inf_in = 1'b0; out_ready = 1'b1;
    held = '0; stall_prev = 1'b0; saw_low = 1'b0; idx = 0; emitted = 0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.result", 32'(result), 32'h0);
    chk("rst.flags", 32'({ovf, unf, inexact}), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel.in_ready", 32'(in_ready), 32'd1);
    chk("rel.out_valid", 32'(out_valid), 32'd0);

    // Normal products and rounding
    beat("one",      1'b0, 7'd15, 22'h100000, 1'b0, 1'b0, 16'h3C00, 1'b0, 1'b0, 1'b0);
    beat("2p25",     1'b0, 7'd15, 22'h240000, 1'b0, 1'b0, 16'h4080, 1'b0, 1'b0, 1'b0);
    beat("tie_even", 1'b0, 7'd15, 22'h100200, 1'b0, 1'b0, 16'h3C00, 1'b0, 1'b0, 1'b1);
    beat("tie_odd",  1'b0, 7'd15, 22'h100600, 1'b0, 1'b0, 16'h3C02, 1'b0, 1'b0, 1'b1);
    beat("max_norm", 1'b0, 7'd30, 22'h1FFC00, 1'b0, 1'b0, 16'h7BFF, 1'b0, 1'b0, 1'b0);

    // Overflow, including overflow caused only by the rounding carry
    beat("ovf",      1'b1, 7'd40, 22'h100000, 1'b0, 1'b0, 16'hFC00, 1'b1, 1'b0, 1'b1);
    beat("ovf_rnd",  1'b0, 7'd29, 22'h3FFFFF, 1'b0, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b1);

    // Specials
    beat("nan",      1'b1, 7'd15, 22'h100000, 1'b1, 1'b0, 16'h7E00, 1'b0, 1'b0, 1'b0);
    beat("inf",      1'b1, 7'd15, 22'h100000, 1'b0, 1'b1, 16'hFC00, 1'b0, 1'b0, 1'b0);
    beat("zero",     1'b1, 7'd5,  22'h000000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);

    // Underflow: exponent -3 (2^-18) and exponent 0 (2^-15)
`ifdef FP16_MULT_SUBNORMAL_EN
    beat("unf_m3",   1'b0, 7'h7D, 22'h100000, 1'b0, 1'b0, 16'h0040, 1'b0, 1'b0, 1'b0);
    beat("unf_0",    1'b0, 7'd0,  22'h100000, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0);
`else
    beat("unf_m3",   1'b0, 7'h7D, 22'h100000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    beat("unf_0",    1'b1, 7'd0,  22'h100000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
`endif

    // Backpressure: four beats streamed, out_ready low for three cycles mid-stream
    sign_in = 1'b0; nan_in = 1'b0; inf_in = 1'b0;
    for (int c = 0; c < 30 && got.size() < 4; c++) begin
      @(posedge clk); #1;
      out_ready = !(c >= 2 && c < 5);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        exp_in  = bp_e[idx];
        mant_in = bp_m[idx];
      end
      @(negedge clk);
      if (in_valid && !in_ready) saw_low = 1'b1;
      if (stall_prev) begin
        chk("bp.hold_valid", 32'(out_valid), 32'd1);
        chk("bp.hold_result", 32'(result), 32'(held));
      end
      if (out_valid && out_ready) got.push_back(result);
      stall_prev = out_valid && !out_ready;
      held = result;
      if (in_valid && in_ready) idx++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp.in_ready_dropped", 32'(saw_low), 32'd1);
    chk("bp.count", 32'(got.size()), 32'd4);
    for (int k = 0; k < got.size() && k < 4; k++) chk($sformatf("bp.beat%0d", k), 32'(got[k]), 32'(bp_r[k]));

    // Reset with two beats in flight: neither may ever be emitted
    out_ready = 1'b0;
    in_valid = 1'b1; exp_in = 7'd17; mant_in = 22'h100000;
    @(posedge clk); #1;
    exp_in = 7'd18;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("rip.pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rip.out_valid", 32'(out_valid), 32'd0);
    chk("rip.result", 32'(result), 32'h0);
    chk("rip.in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) emitted++;
    end
    chk("rip.emitted", 32'(emitted), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
